// File: rtl/spi_target.sv
// SPI mode-0 target with a small register bus, RX/TX byte FIFOs and a level IRQ.
// The SPI pins are asynchronous and are oversampled in the sysclock domain.
`timescale 1ns/1ps
module spi_target #(
    parameter int DEPTH = 8
) (
    input  logic        sysclock,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [1:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    output logic        ack_o,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_ss_n,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // Bus and register state
    logic        r_ack;
    logic [31:0] r_dat;
    logic [2:0]  r_ctrl;
    logic [7:0]  r_fill;
    logic        r_rx_ovf, r_tx_unf, r_tx_ovf;
    logic        r_irq;

    // Pin synchronizers; bit [2] of sclk/ss is the previous synced value for edge detect
    logic [2:0]  r_sclk_sync, r_ss_sync;
    logic [1:0]  r_mosi_sync;

    // SPI engine
    state_t      r_state, w_state_nxt;
    logic        w_start, w_stop;
    logic [2:0]  r_bitcnt;
    logic [6:0]  r_rx_sh;
    logic [6:0]  r_tx_sh;
    logic        r_miso, r_oe;

    // FIFOs: pointers carry one extra bit so count = wr - rd covers 0..DEPTH
    logic [7:0]  r_rx_mem [DEPTH];
    logic [7:0]  r_tx_mem [DEPTH];
    logic [AW:0] r_rx_wr, r_rx_rd, r_tx_wr, r_tx_rd;

    logic        w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise, w_mosi;
    logic [AW:0] w_rx_cnt, w_tx_cnt;
    logic [4:0]  w_rx_cnt5, w_tx_cnt5;
    logic        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic [7:0]  w_rx_head, w_tx_head, w_tx_next, w_rx_byte;
    logic        w_req, w_rd, w_wr;
    logic        w_rx_pop, w_rx_push, w_rx_push_ok;
    logic        w_tx_wr, w_tx_push_ok, w_tx_load, w_tx_pop;
    logic        w_active_run;
    logic [31:0] w_status, w_rdata;
    logic        w_unused;

    assign w_unused = ^{dat_i[31:8], sel_i[3:1]};

    always_ff @(posedge sysclock or posedge rst_i) begin
        if (rst_i) begin
            r_sclk_sync <= 3'b000;
            r_ss_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], spi_sclk};
            r_ss_sync   <= {r_ss_sync[1:0], spi_ss_n};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
    assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
    assign w_mosi      = r_mosi_sync[1];

    assign w_rx_cnt   = r_rx_wr - r_rx_rd;
    assign w_tx_cnt   = r_tx_wr - r_tx_rd;
    assign w_rx_cnt5  = 5'(w_rx_cnt);
    assign w_tx_cnt5  = 5'(w_tx_cnt);
    assign w_rx_empty = (w_rx_cnt == '0);
    assign w_tx_empty = (w_tx_cnt == '0);
    assign w_rx_full  = (w_rx_cnt == PTR_FULL);
    assign w_tx_full  = (w_tx_cnt == PTR_FULL);
    assign w_rx_head  = r_rx_mem[r_rx_rd[AW-1:0]];
    assign w_tx_head  = r_tx_mem[r_tx_rd[AW-1:0]];

    // Bus decode: the access takes effect on the edge that raises ack
    assign w_req = cyc_i & stb_i & ~r_ack;
    assign w_rd  = w_req & ~we_i;
    assign w_wr  = w_req & we_i & sel_i[0];

    always_ff @(posedge sysclock or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_ctrl[0] && w_ss_fall) begin
                    w_state_nxt = ACTIVE;
                    w_start     = 1'b1;
                end
            end
            ACTIVE: begin
                if (!r_ctrl[0] || w_ss_rise) begin
                    w_state_nxt = IDLE;
                    w_stop      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_active_run = (r_state == ACTIVE) & ~w_stop;
    // A TX byte is fetched at select and at every byte-boundary falling edge
    assign w_tx_load = w_start | (w_active_run & w_sclk_fall & (r_bitcnt == 3'd0));
    assign w_tx_pop  = w_tx_load & ~w_tx_empty;
    assign w_tx_next = w_tx_empty ? r_fill : w_tx_head;

    assign w_rx_byte    = {r_rx_sh, w_mosi};
    assign w_rx_push    = w_active_run & w_sclk_rise & (r_bitcnt == 3'd7);
    assign w_rx_pop     = w_rd & (adr_i == 2'd0) & ~w_rx_empty;
    assign w_rx_push_ok = w_rx_push & (~w_rx_full | w_rx_pop);

    assign w_tx_wr      = w_wr & (adr_i == 2'd0);
    assign w_tx_push_ok = w_tx_wr & (~w_tx_full | w_tx_pop);

    always_ff @(posedge sysclock or posedge rst_i) begin
        if (rst_i) begin
            r_bitcnt <= 3'd0;
            r_rx_sh  <= 7'd0;
            r_tx_sh  <= 7'd0;
            r_miso   <= 1'b0;
            r_oe     <= 1'b0;
        end else if (w_start) begin
            r_bitcnt <= 3'd0;
            r_tx_sh  <= w_tx_next[6:0];
            r_miso   <= w_tx_next[7];
            r_oe     <= 1'b1;
        end else if (w_stop) begin
            r_bitcnt <= 3'd0;
            r_miso   <= 1'b0;
            r_oe     <= 1'b0;
        end else if (r_state == ACTIVE) begin
            if (w_sclk_rise) begin
                r_rx_sh  <= {r_rx_sh[5:0], w_mosi};
                r_bitcnt <= r_bitcnt + 3'd1;
            end else if (w_sclk_fall) begin
                if (r_bitcnt == 3'd0) begin
                    r_tx_sh <= w_tx_next[6:0];
                    r_miso  <= w_tx_next[7];
                end else begin
                    r_tx_sh <= {r_tx_sh[5:0], 1'b0};
                    r_miso  <= r_tx_sh[6];
                end
            end
        end
    end

    always_ff @(posedge sysclock or posedge rst_i) begin
        if (rst_i) begin
            r_rx_wr <= '0;
            r_rx_rd <= '0;
            r_tx_wr <= '0;
            r_tx_rd <= '0;
        end else begin
            if (w_rx_push_ok) r_rx_wr <= r_rx_wr + PTR_ONE;
            if (w_rx_pop)     r_rx_rd <= r_rx_rd + PTR_ONE;
            if (w_tx_push_ok) r_tx_wr <= r_tx_wr + PTR_ONE;
            if (w_tx_pop)     r_tx_rd <= r_tx_rd + PTR_ONE;
        end
    end

    always_ff @(posedge sysclock) begin
        if (w_rx_push_ok) r_rx_mem[r_rx_wr[AW-1:0]] <= w_rx_byte;
        if (w_tx_push_ok) r_tx_mem[r_tx_wr[AW-1:0]] <= dat_i[7:0];
    end

    assign w_status = {11'h0, w_tx_cnt5, 3'h0, w_rx_cnt5,
                       ~r_ss_sync[1], r_tx_ovf, r_tx_unf, r_rx_ovf,
                       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};

    always_comb begin
        w_rdata = 32'h0;
        case (adr_i)
            2'd0:    w_rdata = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = {29'h0, r_ctrl};
            default: w_rdata = {24'h0, r_fill};
        endcase
    end

    always_ff @(posedge sysclock or posedge rst_i) begin
        if (rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= 32'h0;
            r_ctrl   <= 3'h0;
            r_fill   <= 8'hFF;
            r_rx_ovf <= 1'b0;
            r_tx_unf <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req) r_dat <= w_rd ? w_rdata : 32'h0;
            if (w_wr && adr_i == 2'd2) r_ctrl <= dat_i[2:0];
            if (w_wr && adr_i == 2'd3) r_fill <= dat_i[7:0];
            // Clear first so a same-cycle hardware event still wins
            if (w_wr && adr_i == 2'd1) begin
                if (dat_i[4]) r_rx_ovf <= 1'b0;
                if (dat_i[5]) r_tx_unf <= 1'b0;
                if (dat_i[6]) r_tx_ovf <= 1'b0;
            end
            if (w_rx_push && w_rx_full && !w_rx_pop) r_rx_ovf <= 1'b1;
            if (w_tx_load && w_tx_empty)             r_tx_unf <= 1'b1;
            if (w_tx_wr && w_tx_full && !w_tx_pop)   r_tx_ovf <= 1'b1;
            r_irq <= r_ctrl[0] & ((r_ctrl[1] & ~w_rx_empty) | (r_ctrl[2] & w_tx_empty));
        end
    end

    assign ack_o       = r_ack;
    assign dat_o       = r_dat;
    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_oe;
    assign irq         = r_irq;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bus reads and MISO bytes are checked by
// monitors against expectation queues filled when stimulus is issued.
`timescale 1ns/1ps
module tb_spi_target;

    localparam int  DEPTH = 8;
    localparam time HALF  = 60;

    logic        sysclock = 1'b0;
    logic        rst_i    = 1'b1;
    logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [1:0]  adr_i = 2'd0;
    logic [31:0] dat_i = 32'h0;
    logic [3:0]  sel_i = 4'h0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        spi_sclk = 1'b0, spi_mosi = 1'b0, spi_ss_n = 1'b1;
    logic        spi_miso, spi_miso_oe, irq;

    spi_target #(.DEPTH(DEPTH)) dut (
        .sysclock(sysclock), .rst_i(rst_i),
        .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
        .dat_i(dat_i), .dat_o(dat_o), .sel_i(sel_i), .ack_o(ack_o),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq)
    );

    always #5 sysclock = ~sysclock;

    int          n_chk = 0, n_pass = 0;
    logic [31:0] bexp_q[$], bmsk_q[$];
    string       bnm_q[$];
    logic [7:0]  mexp_q[$];
    string       mnm_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, want %08h", nm, act, exp);
    endtask

    // Bus read monitor
    logic [31:0] mon_e, mon_m;
    string       mon_nm;
    always @(negedge sysclock) begin
        if (ack_o && !we_i) begin
            if (bexp_q.size() == 0) begin
                n_chk++;
                $display("FAIL bus_extra_read: dat_o %08h with nothing expected", dat_o);
            end else begin
                mon_e  = bexp_q.pop_front();
                mon_m  = bmsk_q.pop_front();
                mon_nm = bnm_q.pop_front();
                chk(mon_nm, dat_o & mon_m, mon_e & mon_m);
            end
        end
    end

    // MISO monitor: initiator samples on sclk rise; ss_n high discards partial bytes
    logic [7:0] msh = 8'h0;
    int         mbc = 0;
    always @(posedge spi_sclk or posedge spi_ss_n) begin
        if (spi_ss_n) mbc = 0;
        else begin
            msh = {msh[6:0], spi_miso};
            mbc++;
            if (mbc == 8) begin
                mbc = 0;
                if (mexp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL miso_extra_byte: got %02h, nothing expected", msh);
                end else chk(mnm_q.pop_front(), {24'h0, msh}, {24'h0, mexp_q.pop_front()});
            end
        end
    end

    task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge sysclock);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = a; dat_i = d; sel_i = s;
        n = 0;
        do begin
            @(negedge sysclock);
            n++;
        end while (!ack_o && n < 16);
        if (!ack_o) begin
            n_chk++;
            $display("FAIL bus_ack_timeout: no ack after %0d cycles", n);
        end else chk("ack_latency", n, 1);
        #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b1, a, d, 4'hF);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        bexp_q.push_back(e);
        bmsk_q.push_back(32'hFFFF_FFFF);
        bnm_q.push_back(nm);
        bus(1'b0, a, 32'h0, 4'hF);
    endtask

    task automatic mexp(input logic [7:0] b, input string nm);
        mexp_q.push_back(b);
        mnm_q.push_back(nm);
    endtask

    task automatic ss_lo();
        spi_ss_n = 1'b0;
        #200;
    endtask

    task automatic ss_hi();
        #100;
        spi_ss_n = 1'b1;
        #200;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            #HALF spi_sclk = 1'b1;
            #HALF spi_sclk = 1'b0;
        end
    endtask

    task automatic do_reset();
        spi_ss_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        #200;
        @(negedge sysclock);
        rst_i = 1'b1;
        #23 rst_i = 1'b0;
        @(negedge sysclock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] pat;
        logic [7:0] v;

        // Reset state, sampled while reset is held
        #23;
        chk("rst_ack", ack_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_irq", irq, 0);
        chk("rst_miso", spi_miso, 0);
        chk("rst_oe", spi_miso_oe, 0);
        rst_i = 1'b0;
        rd(2'd1, 32'h0000_0005, "A_status_reset");
        rd(2'd3, 32'h0000_00FF, "A_fill_reset");
        rd(2'd2, 32'h0, "A_ctrl_reset");

        // Held request: acks alternate, one per access
        @(negedge sysclock);
        cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 2'd3; dat_i = 32'hFF; sel_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclock);
            pat[3-i] = ack_o;
        end
        #1 cyc_i = 0; stb_i = 0; we_i = 0;
        chk("ack_pattern", {28'h0, pat}, 32'hA);

        // A: basic byte exchange; sel_i[0]=0 write is ignored
        wr(2'd2, 32'h1);
        bus(1'b1, 2'd2, 32'h0, 4'hE);
        rd(2'd2, 32'h1, "A_ctrl_sel_gated");
        wr(2'd0, 32'hA5);
        rd(2'd1, 32'h0001_0001, "A_status_tx1");
        mexp(8'hA5, "A_miso");
        ss_lo(); spi_bits(8'h3C, 8); ss_hi();
        rd(2'd1, 32'h0000_0124, "A_status_after");
        rd(2'd0, 32'h3C, "A_rx_byte");
        rd(2'd0, 32'h0, "A_rx_empty_read");
        rd(2'd1, 32'h0000_0025, "A_status_drained");

        // B: underflow sends FILL, sticky clear
        do_reset();
        wr(2'd2, 32'h1);
        wr(2'd3, 32'h5A);
        mexp(8'h5A, "B_miso0"); mexp(8'h5A, "B_miso1");
        ss_lo(); spi_bits(8'h11, 8); spi_bits(8'h22, 8); ss_hi();
        rd(2'd1, 32'h0000_0224, "B_status_unf");
        wr(2'd1, 32'h20);
        rd(2'd1, 32'h0000_0204, "B_unf_cleared");
        rd(2'd0, 32'h11, "B_rx0");
        rd(2'd0, 32'h22, "B_rx1");

        // C: RX overflow with DEPTH+1 bytes
        do_reset();
        wr(2'd2, 32'h1);
        for (int i = 0; i <= DEPTH; i++) mexp(8'hFF, "C_miso");
        ss_lo();
        for (int i = 0; i <= DEPTH; i++) spi_bits(8'(8'h10 + i), 8);
        ss_hi();
        rd(2'd1, 32'h0000_0836, "C_status_full_ovf");
        for (int i = 0; i < DEPTH; i++) rd(2'd0, 32'(8'h10 + i), "C_rx_order");
        rd(2'd1, 32'h0000_0035, "C_status_drained");

        // D: abort after 5 rises, then a clean byte
        do_reset();
        wr(2'd2, 32'h1);
        wr(2'd0, 32'h81);
        ss_lo(); spi_bits(8'h5A, 5); ss_hi();
        chk("D_oe_after_abort", spi_miso_oe, 0);
        rd(2'd1, 32'h0000_0005, "D_status_no_push");
        mexp(8'hFF, "D_miso_fill");
        ss_lo(); spi_bits(8'hC3, 8); ss_hi();
        rd(2'd0, 32'hC3, "D_rx_intact");
        rd(2'd1, 32'h0000_0025, "D_status_end");

        // E: pop coinciding with push into a full RX FIFO; irq lag
        do_reset();
        wr(2'd2, 32'h3);
        @(negedge sysclock);
        chk("E_irq_idle", irq, 0);
        for (int i = 0; i < DEPTH; i++) mexp(8'hFF, "E_miso");
        ss_lo();
        for (int i = 0; i < DEPTH; i++) spi_bits(8'(8'hE0 + i), 8);
        ss_hi();
        chk("E_irq_rx", irq, 1);
        rd(2'd1, 32'h0000_0826, "E_status_full");
        mexp(8'hFF, "E_miso_race");
        v = 8'h99;
        ss_lo();
        spi_bits(v, 7);
        spi_mosi = v[0];
        #HALF;
        @(negedge sysclock);
        spi_sclk = 1'b1;
        @(negedge sysclock);
        rd(2'd0, 32'hE0, "E_race_pop");
        #40 spi_sclk = 1'b0;
        #HALF;
        ss_hi();
        rd(2'd1, 32'h0000_0826, "E_status_no_ovf");
        for (int i = 1; i < DEPTH; i++) rd(2'd0, 32'(8'hE0 + i), "E_rx_order");
        rd(2'd0, 32'h99, "E_rx_race_byte");
        chk("E_irq_lag_hi", irq, 1);
        @(negedge sysclock);
        chk("E_irq_lag_lo", irq, 0);

        // F: asynchronous reset mid-byte
        do_reset();
        wr(2'd2, 32'h5);
        wr(2'd3, 32'h33);
        rd(2'd3, 32'h33, "F_fill_set");
        chk("F_irq_tx", irq, 1);
        chk("F_dat_held", dat_o, 32'h33);
        ss_lo();
        spi_bits(8'hF0, 4);
        chk("F_oe_active", spi_miso_oe, 1);
        #7 rst_i = 1'b1;
        #1;
        chk("F_rst_ack", ack_o, 0);
        chk("F_rst_dat", dat_o, 0);
        chk("F_rst_irq", irq, 0);
        chk("F_rst_miso", spi_miso, 0);
        chk("F_rst_oe", spi_miso_oe, 0);
        #20 rst_i = 1'b0;
        spi_ss_n = 1'b1;
        #200;
        rd(2'd3, 32'hFF, "F_fill_reset");
        rd(2'd2, 32'h0, "F_ctrl_reset");
        rd(2'd1, 32'h0000_0005, "F_status_reset");

        #100;
        chk("bus_queue_drained", bexp_q.size(), 0);
        chk("miso_queue_drained", mexp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning RX/TX FIFO depth in bytes (power of 2, 2..16).
REQ-002 SHALL have port sysclock  input  1  system clock; all logic is in this domain.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports cyc_i, stb_i, we_i  input  1 each  bus cycle, strobe and write enable.
REQ-005 SHALL have port adr_i  input  2  register word index.
REQ-006 SHALL have ports dat_i and dat_o, 32 bits each (input and output), and sel_i  input  4  byte enables.
REQ-007 SHALL have port ack_o  output  1  bus acknowledge.
REQ-008 SHALL have ports spi_sclk, spi_mosi, spi_ss_n  input  1 each  external SPI initiator pins, asynchronous.
REQ-009 SHALL have ports spi_miso  output  1  serial data out, and spi_miso_oe  output  1  MISO drive enable.
REQ-010 SHALL have port irq  output  1  level interrupt request.

Function
REQ-011 SHALL ack any cycle with cyc_i&stb_i exactly one cycle later, for one cycle; ack_o SHALL be low in the cycle after an ack, and each ack completes one access.
REQ-012 SHALL apply register writes only when sel_i[0]=1, at the ack cycle.
REQ-013 SHALL implement reg 0 DATA: read returns {24'h0, RX head} and pops if non-empty (returns 0 if empty); write pushes dat_i[7:0] to TX FIFO; if TX is full the byte is dropped and tx_ovf is set.
REQ-014 SHALL implement reg 1 STATUS (read): b0 rx_empty, b1 rx_full, b2 tx_empty, b3 tx_full, b4 rx_ovf, b5 tx_unf, b6 tx_ovf, b7 ss active, b12:8 rx count, b20:16 tx count. Write: 1 in b4/b5/b6 clears that sticky flag.
REQ-015 SHALL implement reg 2 CONTROL (read/write): b0 enable, b1 rx_irq_en, b2 tx_irq_en.
REQ-016 SHALL implement reg 3 FILL (read/write): b7:0 is the byte shifted out when the TX FIFO is empty.
REQ-017 SHALL synchronize spi_sclk, spi_mosi and spi_ss_n through 2 flops, then edge-detect in sysclock; supported sclk <= sysclock/8.
REQ-018 SHALL operate in SPI mode 0: sample MOSI on sclk rise, MSB first; update MISO on sclk fall.
REQ-019 SHALL be IDLE when enable=0 or ss is inactive. On a synced ss_n fall with enable=1, SHALL go to ACTIVE: bit count=0, TX shift loaded (TX pop, or FILL with tx_unf set if empty), spi_miso=MSB, spi_miso_oe=1.
REQ-020 In ACTIVE, on each sclk rise SHALL shift the sampled MOSI into the RX shift register and increment bit count 0..7. On the 8th rise, SHALL push the byte to RX (drop and set rx_ovf if full) and wrap count to 0.
REQ-021 In ACTIVE, on each sclk fall SHALL do one of two things: if count=0 (byte boundary), load the next TX byte per REQ-019 and drive its MSB; otherwise shift TX left and drive the next bit.
REQ-022 On a synced ss_n rise SHALL return to IDLE: partial RX byte discarded, count=0, spi_miso_oe=0. Clearing enable mid-transfer SHALL have the same effect.
REQ-023 SHALL accept a FIFO push and pop in the same cycle: count is unchanged, and a push to a full FIFO with a simultaneous pop is accepted. Pointers wrap modulo DEPTH.
REQ-024 SHALL register irq = enable & ((rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty)), one cycle of latency.

Reset
REQ-025 On rst_i SHALL asynchronously clear: ack_o=0, dat_o=0, irq=0, spi_miso=0, spi_miso_oe=0, state IDLE, FIFOs empty, CONTROL=0, sticky flags=0, FILL=8'hFF, sync flops to inactive (ss_n=1, sclk=0).

Verification
REQ-026 Enable, write 8'hA5 to DATA, then the initiator clocks 8'h3C with ss low -> MISO carries A5 MSB first, RX holds 3C, STATUS b0=0, b12:8=1.
REQ-027 TX FIFO empty, FILL=8'h5A, 2-byte transfer -> MISO shows 5A,5A and STATUS b5=1; writing STATUS with b5=1 -> b5=0.
REQ-028 Initiator sends DEPTH+1 bytes with no CPU reads -> rx_full=1, rx_ovf=1, and the first DEPTH bytes read back in order.
REQ-029 ss_n raised after 5 sclk rises -> no RX push, miso_oe=0; the next transfer's first byte is received intact.
REQ-030 DATA read pop coincides with an SPI RX push at a full FIFO -> no overflow and count stays DEPTH; irq tracks rx_empty with 1-cycle lag.
REQ-031 rst_i asserted mid-byte -> all outputs per REQ-025 immediately, FILL reads 8'hFF.
